// File: rtl/mem_port_arbiter_if.sv
// Bundle of I-cache refill, data access, memory port and stall signals around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the core/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                ic_req;
  logic [ADDR_W-1:0]   ic_addr;
  logic                ic_gnt;
  logic                ic_rvalid;
  logic [DATA_W-1:0]   ic_rdata;
  logic                ic_last;
  logic                dm_req;
  logic                dm_we;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic [DATA_W/8-1:0] dm_wstrb;
  logic                dm_done;
  logic [DATA_W-1:0]   dm_rdata;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0]   mem_rdata;
  logic                stall_if;
  logic                stall_mem;

  modport slave (
    input  ic_req, ic_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_rdata,
    output ic_gnt, ic_rvalid, ic_rdata, ic_last, dm_done, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, stall_if, stall_mem
  );

  modport master (
    output ic_req, ic_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_rdata,
    input  ic_gnt, ic_rvalid, ic_rdata, ic_last, dm_done, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache line refills and data loads/stores.
// Define ARB_RR_EN for round-robin tie-breaking; default build gives data priority.
//  state      | meaning
//  IDLE       | arbitrate between ic_req and dm_req
//  IC_BURST   | issue LINE_WORDS line reads, wait for ic_last
//  DM_WR      | single store on the port, dm_done this cycle
//  DM_RD_WAIT | load issued, wait for its read data
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);
  localparam int BW = $clog2(LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

  typedef enum logic [1:0] {IDLE, IC_BURST, DM_WR, DM_RD_WAIT} state_t;

  state_t              state;
  logic [BW-1:0]       beat;
  logic [BW-1:0]       beats_left;
  logic [ADDR_W-1:0]   line_base;
  logic                mem_src_ic;
  logic                ic_gnt;
  logic                dm_done_wr;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [MEM_LAT-1:0]  pipe_v;
  logic [MEM_LAT-1:0]  pipe_ic;
  logic [MEM_LAT-1:0]  pipe_last;
  logic                grant_dm;
  logic                grant_ic;
  logic                ic_rvalid;
  logic                ic_last;
  logic                dm_rd_done;

`ifdef ARB_RR_EN
  logic rr_last_ic;
  assign grant_dm = bus.dm_req & (~bus.ic_req | rr_last_ic);
`else
  assign grant_dm = bus.dm_req;
`endif
  assign grant_ic = bus.ic_req & ~grant_dm;

  // Read responses are routed purely by the tag that travelled with the command.
  assign ic_rvalid  = pipe_v[MEM_LAT-1] & pipe_ic[MEM_LAT-1];
  assign ic_last    = ic_rvalid & pipe_last[MEM_LAT-1];
  assign dm_rd_done = pipe_v[MEM_LAT-1] & ~pipe_ic[MEM_LAT-1];

  assign bus.ic_gnt    = ic_gnt;
  assign bus.ic_rvalid = ic_rvalid;
  assign bus.ic_last   = ic_last;
  assign bus.ic_rdata  = ic_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_done   = dm_done_wr | dm_rd_done;
  assign bus.dm_rdata  = dm_rd_done ? bus.mem_rdata : '0;
  assign bus.mem_en    = mem_en;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.mem_wstrb = mem_wstrb;
  // Stalls are forced low during reset so every output reads 0 immediately.
  assign bus.stall_if  = rst & bus.ic_req & ~ic_last;
  assign bus.stall_mem = rst & bus.dm_req & ~bus.dm_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat       <= '0;
      beats_left <= '0;
      line_base  <= '0;
      mem_src_ic <= 1'b0;
      ic_gnt     <= 1'b0;
      dm_done_wr <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      pipe_v     <= '0;
      pipe_ic    <= '0;
      pipe_last  <= '0;
`ifdef ARB_RR_EN
      rr_last_ic <= 1'b1;
`endif
    end else begin
      ic_gnt     <= 1'b0;
      dm_done_wr <= 1'b0;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_ic[i]   <= pipe_ic[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
      pipe_v[0]    <= mem_en & ~mem_we;
      pipe_ic[0]   <= mem_src_ic;
      pipe_last[0] <= mem_src_ic & (beats_left == '0);

      case (state)
        IDLE: begin
          if (grant_dm) begin
            mem_en     <= 1'b1;
            mem_we     <= bus.dm_we;
            mem_addr   <= bus.dm_addr;
            mem_wdata  <= bus.dm_we ? bus.dm_wdata : '0;
            mem_wstrb  <= bus.dm_we ? bus.dm_wstrb : '0;
            mem_src_ic <= 1'b0;
            dm_done_wr <= bus.dm_we;
            state      <= bus.dm_we ? DM_WR : DM_RD_WAIT;
`ifdef ARB_RR_EN
            rr_last_ic <= 1'b0;
`endif
          end else if (grant_ic) begin
            mem_en     <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= bus.ic_addr & LINE_MASK;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            mem_src_ic <= 1'b1;
            line_base  <= bus.ic_addr & LINE_MASK;
            beat       <= BW'(1);
            beats_left <= BW'(LINE_WORDS - 1);
            ic_gnt     <= 1'b1;
            state      <= IC_BURST;
`ifdef ARB_RR_EN
            rr_last_ic <= 1'b1;
`endif
          end
        end
        IC_BURST: begin
          if (mem_en) begin
            if (beats_left == '0) begin
              mem_en     <= 1'b0;
              mem_addr   <= '0;
              mem_src_ic <= 1'b0;
            end else begin
              mem_addr   <= line_base | ADDR_W'({beat, 2'b00});
              beat       <= beat + BW'(1);
              beats_left <= beats_left - BW'(1);
            end
          end
          if (ic_last) state <= IDLE;
        end
        DM_WR: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
          mem_wstrb <= '0;
          state     <= IDLE;
        end
        DM_RD_WAIT: begin
          mem_en   <= 1'b0;
          mem_addr <= '0;
          if (dm_rd_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
